// File: rtl/jtag_dbg_cmd_bridge.sv
// jtag_dbg_cmd_bridge: system-clock side of the virtual-JTAG debug link, turning TCK update strobes into handshaked commands.
// Defining JTAG_DBG_CMD_SKID_EN adds a one-entry skid buffer behind the command output.
module jtag_dbg_cmd_bridge #(
    parameter int IR_WIDTH    = 2,
    parameter int DR_WIDTH    = 38,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 37
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       vs_uir,
    input  logic                       vs_udr,
    input  logic [IR_WIDTH-1:0]        ir_in,
    input  logic [DR_WIDTH-1:0]        sr,
    input  logic                       cmd_ready,
    input  logic                       overrun_clr,
    output logic [DR_WIDTH-1:0]        jdo,
    output logic                       cmd_valid,
    output logic [IR_WIDTH-1:0]        cmd_ch,
    output logic                       cmd_action,
    output logic [(1<<IR_WIDTH)-1:0]   take_action,
    output logic [(1<<IR_WIDTH)-1:0]   take_no_action,
    output logic                       overrun
);
    localparam int NCH = 1 << IR_WIDTH;
    typedef enum logic {IDLE, PEND} state_t;
    state_t state;
    logic [SYNC_STAGES-1:0] uir_sync, udr_sync, fill;
    logic uir_arm, udr_arm, uir_prev, udr_prev, uir_edge, udr_edge;
    logic [IR_WIDTH-1:0] ir_reg;
    logic pend, accept, load_new, promote, go_idle, drop;
    logic [NCH-1:0] ch_hot;
    assign pend   = (state == PEND);
    assign accept = cmd_valid & cmd_ready;
    assign ch_hot = NCH'(1) << cmd_ch;
    // fill marks when the last sync stage holds a real post-reset sample, so a strobe
    // held high across reset release never looks like a low-to-high transition
    always_ff @(posedge clk) begin
        if (reset) begin
            uir_sync <= '0;
            udr_sync <= '0;
            fill     <= '0;
            uir_arm  <= 1'b0;
            udr_arm  <= 1'b0;
            uir_prev <= 1'b0;
            udr_prev <= 1'b0;
            uir_edge <= 1'b0;
            udr_edge <= 1'b0;
        end else begin
            uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
            uir_arm  <= uir_arm | (fill[SYNC_STAGES-1] & ~uir_sync[SYNC_STAGES-1]);
            udr_arm  <= udr_arm | (fill[SYNC_STAGES-1] & ~udr_sync[SYNC_STAGES-1]);
            uir_prev <= uir_sync[SYNC_STAGES-1];
            udr_prev <= udr_sync[SYNC_STAGES-1];
            uir_edge <= uir_arm & uir_sync[SYNC_STAGES-1] & ~uir_prev;
            udr_edge <= udr_arm & udr_sync[SYNC_STAGES-1] & ~udr_prev;
        end
    end
`ifdef JTAG_DBG_CMD_SKID_EN
    logic skid_full, skid_wr;
    logic [DR_WIDTH-1:0] skid_jdo;
    logic [IR_WIDTH-1:0] skid_ch;
    // the skid entry is always older than a fresh capture, so it wins the output slot
    always_comb begin
        load_new = udr_edge & (~pend | (cmd_ready & ~skid_full));
        skid_wr  = udr_edge & pend & (cmd_ready ~^ skid_full);
        drop     = udr_edge & pend & ~cmd_ready & skid_full;
        promote  = accept & skid_full;
        go_idle  = accept & ~udr_edge & ~skid_full;
    end
`else
    always_comb begin
        drop     = udr_edge & pend & ~cmd_ready;
        load_new = udr_edge & ~drop;
        promote  = 1'b0;
        go_idle  = accept & ~udr_edge;
    end
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            ir_reg         <= '0;
            jdo            <= '0;
            cmd_valid      <= 1'b0;
            cmd_ch         <= '0;
            cmd_action     <= 1'b0;
            take_action    <= '0;
            take_no_action <= '0;
            overrun        <= 1'b0;
`ifdef JTAG_DBG_CMD_SKID_EN
            skid_full      <= 1'b0;
            skid_jdo       <= '0;
            skid_ch        <= '0;
`endif
        end else begin
            if (uir_edge) ir_reg <= ir_in;
            take_action    <= (accept & cmd_action)  ? ch_hot : '0;
            take_no_action <= (accept & ~cmd_action) ? ch_hot : '0;
            overrun        <= drop ? 1'b1 : overrun_clr ? 1'b0 : overrun;
            state          <= (load_new | promote) ? PEND : go_idle ? IDLE : state;
            cmd_valid      <= (load_new | promote) ? 1'b1 : go_idle ? 1'b0 : cmd_valid;
            if (load_new) begin
                jdo        <= sr;
                cmd_ch     <= ir_reg;
                cmd_action <= sr[ACT_BIT];
            end
`ifdef JTAG_DBG_CMD_SKID_EN
            else if (promote) begin
                jdo        <= skid_jdo;
                cmd_ch     <= skid_ch;
                cmd_action <= skid_jdo[ACT_BIT];
            end
            if (skid_wr) begin
                skid_jdo <= sr;
                skid_ch  <= ir_reg;
            end
            skid_full <= skid_wr ? 1'b1 : promote ? 1'b0 : skid_full;
`endif
        end
    end
endmodule

// File: tb/tb_jtag_dbg_cmd_bridge.sv
// tb_jtag_dbg_cmd_bridge: directed bench for jtag_dbg_cmd_bridge with hand-computed expectations.
// Expectations for the JTAG_DBG_CMD_SKID_EN build are selected by the same macro.
module tb_jtag_dbg_cmd_bridge;
    logic clk = 1'b0, reset = 1'b1, vs_uir = 1'b0, vs_udr = 1'b1;
    logic cmd_ready = 1'b0, overrun_clr = 1'b0;
    logic [1:0] ir_in = '0;
    logic [37:0] sr = '0;
    logic [37:0] jdo;
    logic cmd_valid, cmd_action, overrun;
    logic [1:0] cmd_ch;
    logic [3:0] take_action, take_no_action;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    jtag_dbg_cmd_bridge dut (
        .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr),
        .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .overrun_clr(overrun_clr),
        .jdo(jdo), .cmd_valid(cmd_valid), .cmd_ch(cmd_ch), .cmd_action(cmd_action),
        .take_action(take_action), .take_no_action(take_no_action), .overrun(overrun)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_ir(input logic [1:0] v);
        ir_in  = v;
        vs_uir = 1'b1;
        tick(4);
        vs_uir = 1'b0;
        tick(4);
    endtask

    // strobe high for 4 edges (capture on the 4th), then low for 4
    task automatic udr_cmd(input logic [37:0] d);
        sr     = d;
        vs_udr = 1'b1;
        tick(4);
        vs_udr = 1'b0;
        tick(4);
    endtask

    initial begin
        tick(3);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_jdo", jdo, 0);
        chk("rst_ch", cmd_ch, 0);
        chk("rst_act", cmd_action, 0);
        chk("rst_take", {take_action, take_no_action}, 0);
        chk("rst_ovr", overrun, 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("held_valid", cmd_valid, 0);
            chk("held_take", {take_action, take_no_action}, 0);
        end
        chk("held_ovr", overrun, 0);
        vs_udr = 1'b0;
        tick(4);

        set_ir(2'd2);
        sr = 38'h20_0000_1234;
        cmd_ready = 1'b1;
        vs_udr = 1'b1;
        tick(3);
        chk("lat_early", cmd_valid, 0);
        tick();
        chk("lat_valid", cmd_valid, 1);
        chk("lat_jdo", jdo, 38'h20_0000_1234);
        chk("lat_ch", cmd_ch, 2);
        chk("lat_act", cmd_action, 1);
        chk("lat_nopulse", take_action, 0);
        tick();
        chk("acc_pulse", take_action, 4'b0100);
        chk("acc_nopulse", take_no_action, 0);
        chk("acc_idle", cmd_valid, 0);
        vs_udr = 1'b0;
        tick();
        chk("acc_once", take_action, 0);
        cmd_ready = 1'b0;
        tick(4);

        set_ir(2'd1);
        udr_cmd(38'h1F_0000_0055);
        chk("stall_valid", cmd_valid, 1);
        chk("stall_ch", cmd_ch, 1);
        chk("stall_act", cmd_action, 0);
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("stall_hold_v", cmd_valid, 1);
            chk("stall_hold_jdo", jdo, 38'h1F_0000_0055);
        end
        set_ir(2'd0);
        chk("pend_uir_ch", cmd_ch, 1);
        cmd_ready = 1'b1;
        tick();
        chk("stall_pulse", take_no_action, 4'b0010);
        chk("stall_noact", take_action, 0);
        chk("stall_idle", cmd_valid, 0);
        cmd_ready = 1'b0;
        tick();
        chk("stall_once", take_no_action, 0);

        set_ir(2'd3);
        udr_cmd(38'h3F_0000_0001);
        chk("ovr_first", jdo, 38'h3F_0000_0001);
        udr_cmd(38'h00_0000_0002);
`ifdef JTAG_DBG_CMD_SKID_EN
        chk("skid_noovr", overrun, 0);
        chk("skid_hold", jdo, 38'h3F_0000_0001);
        udr_cmd(38'h00_0000_0003);
        chk("skid_ovr", overrun, 1);
        chk("skid_hold2", jdo, 38'h3F_0000_0001);
`else
        chk("ovr_set", overrun, 1);
        chk("ovr_keep", jdo, 38'h3F_0000_0001);
        chk("ovr_ch", cmd_ch, 3);
`endif
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_clr", overrun, 0);
        cmd_ready = 1'b1;
        tick();
        chk("ovr_pulse", take_action, 4'b1000);
`ifdef JTAG_DBG_CMD_SKID_EN
        chk("skid_promote_v", cmd_valid, 1);
        chk("skid_promote_jdo", jdo, 38'h00_0000_0002);
        tick();
        chk("skid_pulse2", take_no_action, 4'b1000);
        chk("skid_drain", cmd_valid, 0);
`else
        chk("ovr_idle", cmd_valid, 0);
`endif
        cmd_ready = 1'b0;
        tick();

        udr_cmd(38'h2A_AAAA_AAAA);
        chk("rp_pend", cmd_valid, 1);
        reset = 1'b1;
        tick();
        chk("rp_valid", cmd_valid, 0);
        chk("rp_jdo", jdo, 0);
        reset = 1'b0;
        tick();
        chk("rp_nopulse", {take_action, take_no_action}, 0);
        chk("rp_still_idle", cmd_valid, 0);
        tick(4);
        udr_cmd(38'h15_5555_5555);
        chk("rp_next_v", cmd_valid, 1);
        chk("rp_next_jdo", jdo, 38'h15_5555_5555);
        chk("rp_next_ch", cmd_ch, 0);
        cmd_ready = 1'b1;
        tick();
        chk("rp_next_pulse", take_no_action, 4'b0001);
        cmd_ready = 1'b0;
        tick();

        set_ir(2'd2);
        udr_cmd(38'h00_DEAD_BEEF);
        chk("co_pend", cmd_valid, 1);
        sr = 38'h3C_0BAD_F00D;
        vs_udr = 1'b1;
        tick(3);
        cmd_ready = 1'b1;
        tick();
        chk("co_old_pulse", take_no_action, 4'b0100);
        chk("co_old_noact", take_action, 0);
        chk("co_new_v", cmd_valid, 1);
        chk("co_new_jdo", jdo, 38'h3C_0BAD_F00D);
        chk("co_new_act", cmd_action, 1);
        chk("co_ovr", overrun, 0);
        cmd_ready = 1'b0;
        vs_udr = 1'b0;
        tick();
        chk("co_once", {take_action, take_no_action}, 0);
        chk("co_hold", cmd_valid, 1);
        tick(3);
        cmd_ready = 1'b1;
        tick();
        chk("co_new_pulse", take_action, 4'b0100);
        cmd_ready = 1'b0;
        tick();
        chk("co_done", cmd_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jtag_dbg_cmd_bridge.md
# jtag_dbg_cmd_bridge

System-clock half of the virtual-JTAG debug link, parametrised in IR width, data-register width and synchroniser depth. Synchronises the TCK-domain update strobes, latches the instruction, captures the shifted data register into `jdo`, and presents each update as a channel-tagged command with a valid/ready handshake. On acceptance it emits one-cycle `take_action`/`take_no_action` pulses per channel. It flags commands that arrive while the consumer is stalled.

## Interface
- `IR_WIDTH`, 2, instruction width; channel count `NCH = 2**IR_WIDTH`
- `DR_WIDTH`, 38, data-register width (`sr`/`jdo`)
- `SYNC_STAGES`, 2, synchroniser flops per strobe (legal ≥2)
- `ACT_BIT`, 37, `sr` bit selecting action (1) vs no-action (0)

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `vs_uir` in 1: TCK-domain update-IR strobe, held high ≥ `SYNC_STAGES`+1 `clk` cycles
- `vs_udr` in 1: TCK-domain update-DR strobe, same hold rule
- `ir_in` in `IR_WIDTH`: instruction, stable while `vs_uir` high
- `sr` in `DR_WIDTH`: shift register, stable while `vs_udr` high
- `cmd_ready` in 1: consumer accepts the command
- `overrun_clr` in 1: clears `overrun`
- `jdo` out `DR_WIDTH`: captured data register
- `cmd_valid` out 1: command pending
- `cmd_ch` out `IR_WIDTH`: channel of the pending command
- `cmd_action` out 1: captured `sr[ACT_BIT]`
- `take_action` out `NCH`: one-hot pulse on accept when `cmd_action`=1
- `take_no_action` out `NCH`: one-hot pulse on accept when `cmd_action`=0
- `overrun` out 1: sticky; a command was dropped

## Operation
- Each strobe passes through its own `SYNC_STAGES`-flop chain. A registered rising-edge detector follows the chain.
- Arming: each detector is disarmed at reset. It arms after first sampling its synchronised strobe low. A strobe held high across reset release produces no edge.
- uir edge: `ir_reg` <= `ir_in`.
- udr edge handling depends on the state:
  - IDLE: `jdo` <= `sr`; `cmd_ch` <= `ir_reg`; `cmd_action` <= `sr[ACT_BIT]`; `cmd_valid` <= 1; go to PEND.
  - PEND with `cmd_ready`=1 in the same cycle: the old command is accepted and the new one loaded. State stays PEND.
  - PEND with `cmd_ready`=0: the new command is dropped. `jdo`, `cmd_*` and the state are unchanged, and `overrun` <= 1.
- States: IDLE -> PEND on a udr edge. PEND -> IDLE on `cmd_valid & cmd_ready` with no simultaneous udr edge.
- Accept cycle (`cmd_valid & cmd_ready`): in the next cycle, `take_action[cmd_ch]` pulses if `cmd_action`, otherwise `take_no_action[cmd_ch]` pulses. Exactly one bit is set, for one cycle.
- `cmd_*` and `jdo` are stable while `cmd_valid`=1 and `cmd_ready`=0.
- `overrun`: set/clear priority is set > clear. `overrun_clr` has no other effect.
- A uir edge while in PEND updates `ir_reg` only. The pending `cmd_ch` is unaffected.
- Reset mid-command: the pending command is discarded, no pulse is emitted, and the state returns to IDLE.

## Timing
- Reset values: `jdo`=0, `cmd_valid`=0, `cmd_ch`=0, `cmd_action`=0, `take_action`=0, `take_no_action`=0, `overrun`=0, `ir_reg`=0, sync chains 0, detectors disarmed.
- Capture latency: if `vs_udr` is first sampled high at edge k, then `cmd_valid`, `jdo` and `cmd_*` update at edge k+`SYNC_STAGES`+1.
- IR latency: `ir_reg` updates at edge k+`SYNC_STAGES`+1 after `vs_uir` is first sampled high. A uir→udr gap of at least one `clk` cycle is guaranteed by the TCK state machine.
- Pulse latency: a pulse is asserted the cycle after the accept edge.
- Minimum spacing for back-to-back udr edges is 2·(`SYNC_STAGES`+1) cycles. This is met by the TCK hold rule.

## Configuration
- `JTAG_DBG_CMD_SKID_EN`: defined adds a one-entry skid buffer.
  - A udr edge in PEND with `cmd_ready`=0 stores the command in the skid entry instead of dropping it.
  - The skid entry is promoted to the output on accept, with `cmd_valid` staying 1.
  - `overrun` sets only if the skid entry is already full.
  - `jdo` reflects the output-stage command.
- Undefined: no skid entry; drop-and-flag behaviour as described above.

## Test plan
- Reset release with `vs_udr`=1 held -> no `cmd_valid` and no pulses for 20 cycles; `overrun`=0.
- uir with `ir_in`=2, then udr with `sr`=38'h20_0000_1234, `cmd_ready`=1 -> `cmd_valid` at k+3, `jdo`=38'h20_0000_1234, `take_action`=4'b0100 for one cycle at k+4.
- udr on ch 1 with `sr[37]`=0, `cmd_ready` held 0 for 30 cycles then 1 -> `cmd_valid` and `jdo` stable throughout, then `take_no_action`=4'b0010 one cycle after the accept.
- Two udr commands, `cmd_ready`=0 -> first retained, second dropped, `overrun`=1; `overrun_clr` pulse -> 0.
  - With `JTAG_DBG_CMD_SKID_EN`: both delivered in order and `overrun`=0. A third command sets `overrun`.
- `reset` asserted while in PEND -> `cmd_valid`=0 next cycle, no pulse, next udr captured normally.
- udr edge coincident with accept -> old command pulses, new command valid the next cycle, `overrun`=0.
